// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN             - instruction / address word width
//   PC_STEP          - byte increment between sequential instructions
//   RESET_PC_DEFAULT - default PC loaded by reset
//   fetch_entry_t    - one fetch-buffer entry {pc, instr}
//   align_pc()       - force a byte address onto an even (word) boundary
package mips_pkg;

  localparam int unsigned XLEN    = 16;
  localparam int unsigned PC_STEP = 2;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t align_pc(input word_t addr);
    return {addr[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: small synchronous FIFO with registered head output.
//   clk   - clock, all updates on rising edge
//   rst   - synchronous active-high reset (pointers, count and storage cleared)
//   flush - synchronous discard of all entries; overrides push and pop
//   push  - write wdata at tail (ignored when full unless popping the same cycle)
//   wdata - entry to write
//   pop   - drop head entry (ignored when empty)
//   rdata - head entry, read straight from storage registers
//   count - number of valid entries (0..DEPTH)
//   empty - count == 0
//   full  - count == DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, redirect handling and a fetch buffer.
//   clk            - clock, all updates on rising edge
//   rst            - synchronous active-high reset, highest priority
//   fetch_en       - allow new fetches
//   imem_addr      - byte address to instruction memory (the PC register)
//   imem_instr     - combinational read data for imem_addr
//   redirect_valid - flush buffer and load redirect target (beats push/pop)
//   redirect_pc    - redirect byte address, forced even
//   out_valid      - buffer head is valid
//   out_ready      - decode accepts head
//   out_instr      - head instruction (registered)
//   out_pc         - head byte address (registered)
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc
);

  localparam word_t PcInc = word_t'(PC_STEP);

  word_t                pc_q, pc_d;
  logic                 push, pop, full, empty;
  fetch_entry_t         wr_entry, head_entry;
  logic [2*XLEN-1:0]    head_raw;
  logic [$clog2(DEPTH):0] count;

  // Redirect squashes both the pop and the push of its cycle.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  assign wr_entry = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + PcInc;  // wraps modulo 2^16
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_raw),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign head_entry = fetch_entry_t'(head_raw);
  assign imem_addr  = pc_q;
  assign out_valid  = ~empty;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word at byte address a holds a >> 1.
  assign imem_instr = {1'b0, imem_addr[15:1]};

  instr_fetch_unit #(
    .RESET_PC(16'h0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc, input int at_cyc);
    exp_t e;
    e.pc    = pc;
    e.instr = {1'b0, pc[15:1]};
    e.cyc   = at_cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted beat (not squashed by redirect or reset) is scored.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_pc", {16'h0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_pc", {16'h0, out_pc}, {16'h0, e.pc});
        check("beat_instr", {16'h0, out_instr}, {16'h0, e.instr});
        check("beat_cycle", cyc, e.cyc);
      end
    end
  end

  // Redirect in the next cycle; expect nbeats sequential beats from cycle c+2.
  task automatic redirect_to(input logic [15:0] tgt, input int nbeats, input logic rdy);
    logic [15:0] base;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    out_ready      = rdy;
    last_c         = cyc;
    base           = tgt & 16'hFFFE;
    for (int i = 0; i < nbeats; i++) push_exp(base + 16'(2 * i), last_c + 2 + i);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("valid_after_redirect", {31'h0, out_valid}, 32'h0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", {16'h0, out_pc}, 32'h0);
    check("rst_out_instr", {16'h0, out_instr}, 32'h0);
    check("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

    // In-order streaming from RESET_PC: fetch in first rst=0 cycle, beat next.
    @(posedge clk); #1;
    rst = 1'b0;
    last_c = cyc;
    check("first_cycle_valid", {31'h0, out_valid}, 32'h0);
    push_exp(16'h0000, last_c + 1);
    push_exp(16'h0002, last_c + 2);
    push_exp(16'h0004, last_c + 3);
    wait_drain("stream_timeout");

    // Redirects back to back
    redirect_to(16'h0070, 1, 1'b1);
    wait_drain("redir70_timeout");
    redirect_to(16'h0090, 1, 1'b1);
    wait_drain("redir90_timeout");

    // Backpressure: out_ready low for 5 cycles starting at pc 0x0010
    redirect_to(16'h0010, 0, 1'b0);
    push_exp(16'h0010, last_c + 5);
    push_exp(16'h0012, last_c + 6);
    push_exp(16'h0014, last_c + 7);
    @(negedge clk);
    @(negedge clk);
    check("bp_addr_held_a", {16'h0, imem_addr}, 32'h14);
    @(negedge clk);
    check("bp_addr_held_b", {16'h0, imem_addr}, 32'h14);
    check("bp_head_valid", {31'h0, out_valid}, 32'h1);
    check("bp_head_pc", {16'h0, out_pc}, 32'h10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("bp_timeout");

    // Wrap and odd target
    redirect_to(16'hFFFC, 3, 1'b1);
    wait_drain("wrap_timeout");
    redirect_to(16'h0071, 1, 1'b1);
    wait_drain("odd_timeout");

    // Redirect colliding with a pop while full
    redirect_to(16'h0020, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("coll_full_addr", {16'h0, imem_addr}, 32'h24);
    check("coll_full_valid", {31'h0, out_valid}, 32'h1);
    redirect_to(16'h0040, 1, 1'b1);
    wait_drain("coll_timeout");

    // fetch_en low holds pc with no push
    fetch_en = 1'b0;
    redirect_to(16'h0030, 0, 1'b1);
    @(negedge clk);
    check("fe0_addr_held", {16'h0, imem_addr}, 32'h30);
    check("fe0_no_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    fetch_en = 1'b1;
    push_exp(16'h0030, cyc + 1);
    wait_drain("fe_timeout");

    // Reset mid-stream with two entries buffered
    redirect_to(16'h0050, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_full_addr", {16'h0, imem_addr}, 32'h54);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_c = cyc;
    push_exp(16'h0000, last_c + 1);
    push_exp(16'h0002, last_c + 2);
    @(negedge clk);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    wait_drain("mid_rst_timeout");

    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2: fetch-buffer entries; power of two, at least 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port fetch_en, input, 1 bit: permits new fetches when high.
REQ-007 SHALL have port imem_addr, output, 16 bits: byte address to the instruction memory; always equal to the PC register.
REQ-008 SHALL have port imem_instr, input, 16 bits: combinational memory read data, valid in the same cycle as imem_addr.
REQ-009 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-010 SHALL have port redirect_pc, input, 16 bits: redirect target byte address.
REQ-011 SHALL have port out_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-012 SHALL have port out_ready, input, 1 bit: decode accepts the head entry.
REQ-013 SHALL have port out_instr, output, 16 bits: head instruction.
REQ-014 SHALL have port out_pc, output, 16 bits: byte address of the head instruction.

Function
REQ-015 SHALL treat memory as 16-bit words at even byte addresses; PC SHALL always be even.
REQ-016 SHALL push {pc, imem_instr} into the buffer and set pc <= pc + 2 in a cycle where fetch_en=1, redirect_valid=0, and (count < DEPTH or a pop occurs).
REQ-017 SHALL pop the head on a cycle where out_valid=1 and out_ready=1.
REQ-018 SHALL drive out_valid=1 exactly when count > 0; out_instr and out_pc SHALL come from the head entry, registered, with no combinational path from imem_instr.
REQ-019 SHALL have latency of one cycle: an instruction fetched in cycle N appears on out_* in cycle N+1 at the earliest.
REQ-020 SHALL, on redirect_valid=1, discard all buffered entries, ignore any pop, suppress the push in that cycle, and set pc <= {redirect_pc[15:1],1'b0}.
REQ-021 SHALL give redirect priority over push and pop; out_valid SHALL be 0 in the cycle after a redirect.
REQ-022 SHALL, when full with no pop, hold pc and not overwrite or duplicate any entry.
REQ-023 SHALL handle a simultaneous push and pop with count unchanged and entry order preserved.
REQ-024 SHALL, when fetch_en=0, hold pc with no push; pops continue normally.
REQ-025 SHALL wrap pc modulo 2^16: 16'hFFFE + 2 = 16'h0000, with no error flag.
REQ-026 SHALL keep buffer read/write pointers log2(DEPTH) bits wide, wrapping naturally, and the count log2(DEPTH)+1 bits wide.
REQ-027 SHALL NOT present out_pc/out_instr as meaningful while out_valid=0; the held value is don't-care.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set pc=RESET_PC, pointers=0, count=0, out_valid=0, out_pc=0, out_instr=0.
REQ-029 SHALL give rst priority over redirect_valid, push and pop.
REQ-030 SHALL, when reset is asserted mid-stream, drop all buffered instructions, with no output beat in the following cycle.
REQ-031 SHALL permit the first fetch at RESET_PC in the first cycle with rst=0, and SHALL assert out_valid in the next cycle.

Structure
REQ-032 SHALL place word width (16), PC_STEP (2) and the default RESET_PC in shared package mips_pkg.
REQ-033 SHALL implement the buffer as sub-module fetch_fifo (parameters DEPTH and WIDTH=32), with a synchronous flush input.
REQ-034 SHALL keep the PC register, redirect logic and push/pop control in instr_fetch_unit.

Verification
REQ-035 SHALL cover in-order streaming: memory model instr = addr>>1; reset, fetch_en=1, out_ready=1 -> out_pc 0x0000,0x0002,0x0004 with out_instr 0,1,2 on consecutive cycles.
REQ-036 SHALL cover redirect: redirect to 0x0070 -> next beat pc 0x0070, instr 56; then redirect to 0x0090 -> pc 0x0090, instr 72; no stale beat between.
REQ-037 SHALL cover backpressure: out_ready=0 for 5 cycles from pc 0x0010 -> count saturates at 2, imem_addr held at 0x0014; after release, beats 0x0010,0x0012,0x0014 with no gap, skip or duplicate.
REQ-038 SHALL cover wrap and odd target: redirect to 0xFFFC -> beats 0xFFFC,0xFFFE,0x0000; redirect to 0x0071 -> beat pc 0x0070, instr 56.
REQ-039 SHALL cover redirect collisions: redirect asserted in the same cycle as a pop while full -> buffer flushed, out_valid=0 next cycle, then the target beat follows.
REQ-040 SHALL cover reset mid-stream: rst pulsed with 2 entries buffered -> out_valid=0 the next cycle, and the stream restarts at RESET_PC.
